// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings, master state types and command legality helper
// for the single-transfer AHB-Lite initiator.
//
// Contents:
//   HTRANS_*, HSIZE_*, HBURST_SINGLE, HRESP_*  AHB-Lite field encodings
//   bus_state_e                                running / two-cycle ERROR handling
//   dbg_state_t                                observable master state
//   cmd_legal()                                size/alignment check on a command
package ahb_lite_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // ST_ERR spans the cycles between the first (HREADY=0) and second
  // (HREADY=1) cycle of a slave ERROR response.
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } bus_state_e;

  typedef struct packed {
    bus_state_e state;
    logic       a_vld;
    logic       d_vld;
  } dbg_state_t;

  // Byte, half and word transfers only; half needs addr[0]=0, word addr[1:0]=0.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: cmd_legal = 1'b1;
      HSIZE_HALF: cmd_legal = ~addr_lo[0];
      HSIZE_WORD: cmd_legal = (addr_lo == 2'b00);
      default:    cmd_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator. Turns a valid/ready command stream into
// NONSEQ SINGLE transfers, overlapping the next address phase with the current
// data phase, and returns exactly one in-order response per accepted command.
//
// Ports:
//   HCLK, HRESET            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write/addr/size/wdata  command fields (wdata captured at acceptance)
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response pulse, no backpressure
//   HADDR..HWDATA           registered AHB-Lite master outputs
//   HRDATA/HREADY/HRESP     AHB-Lite fabric inputs
//   dbg_state               current slot flags and error state
//
// Handshake: a command transfers on every rising HCLK where cmd_valid and
// cmd_ready are both 1. cmd_ready is combinational from state, HREADY and the
// command's own size/address, so the initiator may hold cmd_valid with any
// fields and sees cmd_ready rise only once that exact command can be taken.
// rsp_valid is a single-cycle pulse that cannot be stalled.
module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter bit         PIPELINE  = 1'b1,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output dbg_state_t  dbg_state
);

  bus_state_e  state_q, state_d;
  logic        a_vld_q, a_vld_d;     // command in address slot (drives HADDR/HWRITE/HSIZE)
  logic        d_vld_q, d_vld_d;     // command in data slot
  logic        d_write_q, d_write_d; // direction of the data-slot command
  logic [31:0] a_wdata_q, a_wdata_d; // write data waiting for its data phase

  logic [31:0] haddr_d;
  logic [1:0]  htrans_d;
  logic [2:0]  hsize_d;
  logic        hwrite_d;
  logic [31:0] hwdata_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_rdata_d;
  logic        rsp_err_d;

  logic legal;
  logic in_err;
  logic slot_ok;
  logic a_adv;
  logic d_done;
  logic accept;
  logic acc_legal;
  logic acc_illegal;

  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_VAL;

  assign dbg_state.state = state_q;
  assign dbg_state.a_vld = a_vld_q;
  assign dbg_state.d_vld = d_vld_q;

  always_comb begin
    legal  = cmd_legal(cmd_size, cmd_addr[1:0]);
    in_err = (state_q == ST_ERR);

    // While in ST_ERR the address slot is parked (HTRANS is IDLE), so the
    // HREADY=1 of the second error cycle must not advance it.
    a_adv  = a_vld_q && !in_err && HREADY;
    d_done = d_vld_q && HREADY;

    // A legal command needs the address slot to be free by the next edge.
    // Without pipelining nothing may remain in flight after this edge, which
    // rules out an address phase still moving into the data slot.
    if (PIPELINE) slot_ok = !a_vld_q || HREADY;
    else          slot_ok = !a_vld_q && (!d_vld_q || HREADY);

    // Illegal commands wait for an empty bus so their error response cannot
    // overtake or collide with a real transfer's response.
    cmd_ready = !HRESET && !in_err &&
                (legal ? slot_ok : (!a_vld_q && !d_vld_q));

    accept      = cmd_valid && cmd_ready;
    acc_legal   = accept && legal;
    acc_illegal = accept && !legal;

    state_d     = state_q;
    a_vld_d     = a_vld_q;
    d_vld_d     = d_vld_q;
    d_write_d   = d_write_q;
    a_wdata_d   = a_wdata_q;
    haddr_d     = HADDR;
    hsize_d     = HSIZE;
    hwrite_d    = HWRITE;
    hwdata_d    = HWDATA;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    // Data slot: completes on HREADY; a lone HRESP=1 with HREADY=0 is the
    // first cycle of an ERROR response.
    if (d_done) begin
      d_vld_d     = 1'b0;
      state_d     = ST_RUN;
      rsp_valid_d = 1'b1;
      rsp_err_d   = (HRESP == HRESP_ERROR);
      rsp_rdata_d = (HRESP == HRESP_OKAY && !d_write_q) ? HRDATA : '0;
    end else if (d_vld_q && HRESP == HRESP_ERROR) begin
      state_d = ST_ERR;
    end

    // Address slot hands over to the data slot; HWDATA follows one cycle later.
    if (a_adv) begin
      a_vld_d   = 1'b0;
      d_vld_d   = 1'b1;
      d_write_d = HWRITE;
      hwdata_d  = a_wdata_q;
    end

    if (acc_legal) begin
      a_vld_d   = 1'b1;
      haddr_d   = cmd_addr;
      hsize_d   = cmd_size;
      hwrite_d  = cmd_write;
      a_wdata_d = cmd_wdata;
    end

    if (acc_illegal) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end

    // A pending address phase is hidden (IDLE) for the rest of an ERROR
    // response and reappears as NONSEQ once the error completes.
    htrans_d = (a_vld_d && state_d == ST_RUN) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_RUN;
      a_vld_q   <= 1'b0;
      d_vld_q   <= 1'b0;
      d_write_q <= 1'b0;
      a_wdata_q <= '0;
      HADDR     <= '0;
      HTRANS    <= HTRANS_IDLE;
      HSIZE     <= HSIZE_WORD;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_vld_q   <= a_vld_d;
      d_vld_q   <= d_vld_d;
      d_write_q <= d_write_d;
      a_wdata_q <= a_wdata_d;
      HADDR     <= haddr_d;
      HTRANS    <= htrans_d;
      HSIZE     <= hsize_d;
      HWRITE    <= hwrite_d;
      HWDATA    <= hwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: a memory-backed AHB-Lite slave with configurable
// wait states and a two-cycle ERROR for addresses with addr[7:4]=F, an
// acceptance monitor feeding a command-level reference model, and a response
// scoreboard. Stimulus: a vector table, hand-timed corner sequences, then a
// randomized command stream.
module tb_ahb_lite_master;
  import ahb_lite_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE, HREADY, HRESP;
  dbg_state_t  dbg_state;

  ahb_lite_master #(.PIPELINE(1'b1), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .dbg_state(dbg_state)
  );

  // ---------------- counters / checker ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [29:0]];
  logic [32:0] exp_q[$];   // {err, rdata}
  bit          tbl_mode = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [32:0] model_rsp(input logic wr, input logic [31:0] a,
                                            input logic [2:0] sz, input logic [31:0] wd);
    logic        ok;
    logic        err;
    logic [31:0] rd;
    ok  = (sz <= 3'd2) && ((a % (32'd1 << sz)) == 32'd0);
    err = !ok || (a[7:4] == 4'hF);
    rd  = 32'h0;
    if (!err) begin
      if (wr) ref_mem[a[31:2]] = wd;
      else    rd = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a);
    end
    return {err, rd};
  endfunction

  // Acceptance monitor: every accepted command advances the model.
  always @(negedge HCLK) begin
    logic [32:0] r;
    if (!HRESET && cmd_valid && cmd_ready) begin
      r = model_rsp(cmd_write, cmd_addr, cmd_size, cmd_wdata);
      if (!tbl_mode) exp_q.push_back(r);
    end
  end

  // Response scoreboard.
  always @(negedge HCLK) begin
    logic [32:0] e;
    if (!HRESET && rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got err=%b rdata=%h, expected no response", rsp_err, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
        check("rsp_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  // ---------------- AHB slave model ----------------
  logic [31:0] smem [logic [29:0]];
  logic [31:0] s_haddr, s_hwdata;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  bit          dp_active, dp_write, dp_err, dp_err2;
  logic [31:0] dp_addr;
  int          dp_wait;
  int          cfg_wait = 0;
  bit          rand_wait = 1'b0;
  bit          rand_idle = 1'b0;

  always @(negedge HCLK) begin
    s_haddr  = HADDR;
    s_hwdata = HWDATA;
    s_htrans = HTRANS;
    s_hwrite = HWRITE;
  end

  initial begin
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    dp_active = 1'b0; dp_write = 1'b0; dp_err = 1'b0; dp_err2 = 1'b0;
    dp_addr = '0; dp_wait = 0;
    forever begin
      @(posedge HCLK); #1;
      if (HRESET) begin
        dp_active = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      end else begin
        if (HREADY && dp_active) begin
          if (dp_write && !dp_err) smem[dp_addr[31:2]] = s_hwdata;
          dp_active = 1'b0;
        end
        if (HREADY && s_htrans == HTRANS_NONSEQ) begin
          dp_active = 1'b1; dp_addr = s_haddr; dp_write = s_hwrite;
          dp_err = (s_haddr[7:4] == 4'hF); dp_err2 = 1'b0;
          dp_wait = rand_wait ? int'($urandom_range(0, 3)) : cfg_wait;
        end
        if (dp_active) begin
          if (dp_wait > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom; dp_wait--;
          end else if (dp_err) begin
            HRESP = 1'b1; HREADY = dp_err2; dp_err2 = 1'b1; HRDATA = $urandom;
          end else begin
            HREADY = 1'b1; HRESP = 1'b0;
            if (dp_write) HRDATA = $urandom;
            else HRDATA = smem.exists(dp_addr[31:2]) ? smem[dp_addr[31:2]] : init_word(dp_addr);
          end
        end else begin
          HRESP  = 1'b0;
          HREADY = (rand_idle && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
          HRDATA = $urandom;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returns at posedge+2.
  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, output int waited);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    waited = 0;
    @(negedge HCLK);
    while (!cmd_ready && waited < 200) begin
      waited++;
      @(negedge HCLK);
    end
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: cmd_ready low for %0d cycles, expected acceptance", waited);
    end
    @(posedge HCLK); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge HCLK); #2;
      c++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK); #2;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    int found;
    int nonseq_seen;
    int snap;
    logic        w;
    logic [2:0]  sz;
    logic [31:0] a;

    vecs[0]  = '{wr:1'b1, addr:32'h1000, size:3'd2, wdata:32'hDEAD_BEEF, waits:0, exp_err:1'b0, exp_rdata:32'h0};
    vecs[1]  = '{wr:1'b0, addr:32'h1000, size:3'd2, wdata:32'h0,         waits:0, exp_err:1'b0, exp_rdata:32'hDEAD_BEEF};
    vecs[2]  = '{wr:1'b1, addr:32'h1004, size:3'd1, wdata:32'h0000_CAFE, waits:1, exp_err:1'b0, exp_rdata:32'h0};
    vecs[3]  = '{wr:1'b0, addr:32'h1004, size:3'd1, wdata:32'h0,         waits:2, exp_err:1'b0, exp_rdata:32'h0000_CAFE};
    vecs[4]  = '{wr:1'b0, addr:32'h1001, size:3'd1, wdata:32'h0,         waits:0, exp_err:1'b1, exp_rdata:32'h0};
    vecs[5]  = '{wr:1'b1, addr:32'h1002, size:3'd2, wdata:32'h1111_2222, waits:0, exp_err:1'b1, exp_rdata:32'h0};
    vecs[6]  = '{wr:1'b0, addr:32'h1000, size:3'd3, wdata:32'h0,         waits:0, exp_err:1'b1, exp_rdata:32'h0};
    vecs[7]  = '{wr:1'b0, addr:32'h1003, size:3'd0, wdata:32'h0,         waits:0, exp_err:1'b0, exp_rdata:32'hDEAD_BEEF};
    vecs[8]  = '{wr:1'b0, addr:32'h10F4, size:3'd2, wdata:32'h0,         waits:1, exp_err:1'b1, exp_rdata:32'h0};
    vecs[9]  = '{wr:1'b1, addr:32'h10F8, size:3'd2, wdata:32'h7777_7777, waits:0, exp_err:1'b1, exp_rdata:32'h0};
    vecs[10] = '{wr:1'b0, addr:32'h2000, size:3'd2, wdata:32'h0,         waits:0, exp_err:1'b0, exp_rdata:32'h5A5A_2000};
    vecs[11] = '{wr:1'b0, addr:32'h1000, size:3'd2, wdata:32'h0,         waits:4, exp_err:1'b0, exp_rdata:32'hDEAD_BEEF};

    // Reset state, with a legal command offered during reset.
    HRESET = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1000; cmd_size = 3'd2; cmd_wdata = 32'h1;
    repeat (2) @(negedge HCLK);
    check("reset_htrans", {30'h0, HTRANS}, {30'h0, HTRANS_IDLE});
    check("reset_haddr", HADDR, 32'h0);
    check("reset_hwrite", {31'h0, HWRITE}, 32'h0);
    check("reset_hsize", {29'h0, HSIZE}, 32'h2);
    check("reset_hwdata", HWDATA, 32'h0);
    check("reset_rsp", {rsp_valid, rsp_err, 30'h0}, 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    check("hburst", {29'h0, HBURST}, 32'h0);
    check("hprot", {28'h0, HPROT}, 32'h3);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK); #2;

    // Table vectors, one at a time.
    tbl_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cfg_wait = vecs[i].waits;
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
      send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, waited);
      wait_idle(50);
    end
    tbl_mode = 1'b0;
    cfg_wait = 0;

    // Write latency: NONSEQ one cycle after accept, HWDATA the cycle after.
    send_cmd(1'b1, 32'h0000_1000, 3'd2, 32'hDEAD_BEEF, waited);
    check("wr_htrans", {30'h0, HTRANS}, {30'h0, HTRANS_NONSEQ});
    check("wr_haddr", HADDR, 32'h0000_1000);
    check("wr_hwrite", {31'h0, HWRITE}, 32'h1);
    idle(1);
    check("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
    idle(1);
    check("wr_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    wait_idle(20);

    // Back-to-back reads overlap address 0x14 with data phase of 0x10.
    send_cmd(1'b0, 32'h10, 3'd2, 32'h0, waited);
    send_cmd(1'b0, 32'h14, 3'd2, 32'h0, waited);
    check("b2b_accept_wait", waited, 0);
    check("b2b_haddr", HADDR, 32'h14);
    check("b2b_htrans", {30'h0, HTRANS}, {30'h0, HTRANS_NONSEQ});
    check("b2b_overlap", {30'h0, dbg_state.a_vld, dbg_state.d_vld}, 32'h3);
    wait_idle(20);

    // Read with 3 wait states: address and write data held, no early response.
    send_cmd(1'b1, 32'h20, 3'd2, 32'h1234_5678, waited);
    wait_idle(20);
    cfg_wait = 3;
    send_cmd(1'b0, 32'h20, 3'd2, 32'hA5A5_A5A5, waited);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("ws_haddr", HADDR, 32'h20);
      check("ws_hwdata", HWDATA, 32'hA5A5_A5A5);
      check("ws_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end
    cfg_wait = 0;
    wait_idle(20);

    // Two-cycle ERROR on the first of two pipelined writes.
    send_cmd(1'b1, 32'h10F0, 3'd2, 32'h5555_0001, waited);
    send_cmd(1'b1, 32'h0200, 3'd2, 32'h0BAD_F00D, waited);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (HRESP && HREADY) begin
        found = 1;
        break;
      end
      idle(1);
    end
    check("err_second_cycle_seen", found, 1);
    check("err_htrans_idle", {30'h0, HTRANS}, {30'h0, HTRANS_IDLE});
    idle(1);
    check("err_reissue_htrans", {30'h0, HTRANS}, {30'h0, HTRANS_NONSEQ});
    check("err_reissue_haddr", HADDR, 32'h0200);
    wait_idle(20);
    send_cmd(1'b0, 32'h0200, 3'd2, 32'h0, waited);
    wait_idle(20);

    // Misaligned word: error response, no bus transfer.
    send_cmd(1'b0, 32'h3, 3'd2, 32'h0, waited);
    check("illegal_rsp", {30'h0, rsp_valid, rsp_err}, 32'h3);
    nonseq_seen = (HTRANS == HTRANS_NONSEQ) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (HTRANS == HTRANS_NONSEQ) nonseq_seen++;
    end
    check("illegal_no_nonseq", nonseq_seen, 0);
    wait_idle(20);

    // Reset during a wait-stated read: bus idles at once, no stale response.
    cfg_wait = 6;
    send_cmd(1'b0, 32'h30, 3'd2, 32'h0, waited);
    idle(1);
    @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    check("rst_mid_htrans", {30'h0, HTRANS}, {30'h0, HTRANS_IDLE});
    check("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_mid_slots", {30'h0, dbg_state.a_vld, dbg_state.d_vld}, 32'h0);
    exp_q.delete();
    cfg_wait = 0;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    snap = n_rsp;
    @(posedge HCLK); #2;
    idle(10);
    check("rst_no_stale_rsp", n_rsp - snap, 0);

    // Randomized stream against the reference model.
    rand_wait = 1'b1;
    rand_idle = 1'b1;
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63)) << 2;
      if (sz == 3'd0)      a = a + 32'($urandom_range(0, 3));
      else if (sz == 3'd1) a = a + 32'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) sz = 3'd3;
        else begin
          sz = 3'd2;
          a  = a + 32'($urandom_range(1, 3));
        end
      end
      send_cmd(w, a, sz, $urandom, waited);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    wait_idle(400);
    rand_wait = 1'b0;
    rand_idle = 1'b0;
    idle(3);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
